// File: rtl/ddr_console_sink.sv
// Display-side sink for the eLC-3 DDR/DSR pair: buffers CPU writes in a small FIFO
// and shows each character on the display output for a fixed hold window.
module ddr_console_sink #(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 50000000
) (
    input  logic        Clk,
    input  logic        Reset_N,
    input  logic        DDR_Write,
    input  logic [15:0] DDR_Data,
    input  logic        Flush,
    output logic        DSR_Ready,
    output logic [15:0] Display_Out,
    output logic        Display_Valid,
    output logic        Overflow,
    output logic [15:0] Char_Count
);

    localparam int AW = $clog2(DEPTH);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

    typedef enum logic {IDLE, SHOW} state_t;

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    state_t        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [15:0]   disp_q, disp_d;
    logic          valid_q, valid_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   chars_q, chars_d;
    logic          full, pop, push;

    always_comb begin
        full = (count_q == FULL_CNT);
        // A pop happens whenever the display is free for a new character this cycle.
        pop  = !Flush && (count_q != '0) && ((state_q == IDLE) || (hold_q == '0));
        push = DDR_Write && !Flush && (!full || pop);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        state_d  = state_q;
        hold_d   = hold_q;
        disp_d   = disp_q;
        valid_d  = valid_q;
        chars_d  = chars_q;
        ovf_d    = ovf_q | (DDR_Write && !Flush && full && !pop);

        if (Flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end

        if (pop) begin
            disp_d  = mem_q[rd_ptr_q];
            valid_d = 1'b1;
            hold_d  = HOLD_LOAD;
            chars_d = chars_q + 16'd1;
            state_d = SHOW;
        end else if (state_q == SHOW) begin
            if (hold_q != '0) begin
                hold_d = hold_q - HW'(1);
            end else begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= IDLE;
            hold_q   <= '0;
            disp_q   <= 16'h0000;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            chars_q  <= 16'h0000;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            hold_q   <= hold_d;
            disp_q   <= disp_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            chars_q  <= chars_d;
        end
    end

    // Storage needs no reset: the count guards every read.
    always_ff @(posedge Clk) begin
        if (push) mem_q[wr_ptr_q] <= DDR_Data;
    end

    assign DSR_Ready     = Reset_N && (count_q < FULL_CNT);
    assign Display_Out   = disp_q;
    assign Display_Valid = valid_q;
    assign Overflow      = ovf_q;
    assign Char_Count    = chars_q;

endmodule

// File: tb/tb_ddr_console_sink.sv
// Bench for ddr_console_sink: directed scenarios plus random traffic against a
// queue-based model of the display sink; a second instance covers Char_Count wrap.
module tb_ddr_console_sink;

    localparam int DEPTH = 4;
    localparam int HOLD  = 4;

    logic        Clk = 1'b0;
    logic        Reset_N;
    logic        DDR_Write;
    logic [15:0] DDR_Data;
    logic        Flush;
    logic        DSR_Ready;
    logic [15:0] Display_Out;
    logic        Display_Valid;
    logic        Overflow;
    logic [15:0] Char_Count;

    logic        w_wr;
    logic [15:0] w_data;
    logic        w_flush;
    logic        w_dsr;
    logic [15:0] w_out;
    logic        w_valid;
    logic        w_ovf;
    logic [15:0] w_cnt;

    int checks = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    ddr_console_sink #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
        .Clk(Clk), .Reset_N(Reset_N), .DDR_Write(DDR_Write), .DDR_Data(DDR_Data),
        .Flush(Flush), .DSR_Ready(DSR_Ready), .Display_Out(Display_Out),
        .Display_Valid(Display_Valid), .Overflow(Overflow), .Char_Count(Char_Count)
    );

    ddr_console_sink #(.DEPTH(DEPTH), .HOLD_CYCLES(1)) dut_fast (
        .Clk(Clk), .Reset_N(Reset_N), .DDR_Write(w_wr), .DDR_Data(w_data),
        .Flush(w_flush), .DSR_Ready(w_dsr), .Display_Out(w_out),
        .Display_Valid(w_valid), .Overflow(w_ovf), .Char_Count(w_cnt)
    );

    // Reference model: pending characters, what is on display, and how many
    // display cycles the current character still has (including this one).
    logic [15:0] mq[$];
    logic [15:0] m_out;
    bit          m_vis;
    int          m_remain;
    bit          m_ovf;
    logic [15:0] m_cnt;

    task automatic model_reset();
        mq.delete();
        m_out = 16'h0000; m_vis = 0; m_remain = 0; m_ovf = 0; m_cnt = 16'h0000;
    endtask

    task automatic model_edge();
        bit take, is_full;
        if (!Reset_N) begin
            model_reset();
            return;
        end
        is_full = (mq.size() == DEPTH);
        take = !Flush && (mq.size() > 0) && (!m_vis || m_remain == 1);
        if (DDR_Write && !Flush && is_full && !take) m_ovf = 1;
        if (take) begin
            m_out = mq.pop_front();
            m_vis = 1;
            m_remain = HOLD;
            m_cnt = m_cnt + 16'd1;
        end else if (m_vis) begin
            if (m_remain == 1) m_vis = 0;
            else m_remain--;
        end
        if (DDR_Write && !Flush && (!is_full || take)) mq.push_back(DDR_Data);
        if (Flush) mq.delete();
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".dsr"},   16'(DSR_Ready),     16'(Reset_N && (mq.size() < DEPTH)));
        chk({tag, ".out"},   Display_Out,        m_out);
        chk({tag, ".valid"}, 16'(Display_Valid), 16'(m_vis));
        chk({tag, ".ovf"},   16'(Overflow),      16'(m_ovf));
        chk({tag, ".cnt"},   Char_Count,         m_cnt);
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge Clk);
        #1;
        compare_all(tag);
    endtask

    task automatic do_reset();
        Reset_N = 1'b0;
        DDR_Write = 1'b0; Flush = 1'b0; DDR_Data = 16'h0000;
        model_reset();
        tick("rst");
        tick("rst");
        Reset_N = 1'b1;
        #1;
        compare_all("rst_rel");
    endtask

    task automatic write1(input logic [15:0] d, input string tag);
        DDR_Write = 1'b1; DDR_Data = d;
        tick(tag);
        DDR_Write = 1'b0;
    endtask

    initial begin
        int vcount;
        int guard;
        Reset_N = 1'b0;
        DDR_Write = 1'b0; DDR_Data = 16'h0000; Flush = 1'b0;
        w_wr = 1'b0; w_data = 16'h0000; w_flush = 1'b0;
        model_reset();

        // Reset values, including DSR_Ready held low while in reset.
        #1;
        chk("rst.dsr_low", 16'(DSR_Ready), 16'h0000);
        chk("rst.out", Display_Out, 16'h0000);
        do_reset();
        chk("rst.dsr_high", 16'(DSR_Ready), 16'h0001);

        // Single character: appears after the edge following the strobe, held 4 cycles.
        write1(16'h0041, "single");
        chk("single.not_yet", 16'(Display_Valid), 16'h0000);
        tick("single");
        chk("single.out", Display_Out, 16'h0041);
        vcount = 0;
        for (int i = 0; i < 8; i++) begin
            if (Display_Valid) vcount++;
            tick("single");
        end
        chk("single.hold_len", 16'(vcount), 16'(HOLD));
        chk("single.keep", Display_Out, 16'h0041);
        chk("single.cnt", Char_Count, 16'h0001);

        // Back-to-back writes 1..6, then 7 while full and mid-hold (dropped).
        for (int i = 1; i <= 6; i++) begin
            write1(16'(i), "burst");
            if (i == 5) chk("burst.dsr_full", 16'(DSR_Ready), 16'h0000);
        end
        chk("burst.ovf_clear", 16'(Overflow), 16'h0000);
        write1(16'h0007, "burst");
        chk("burst.ovf_set", 16'(Overflow), 16'h0001);
        for (int i = 0; i < 30; i++) tick("burst_drain");
        chk("burst.last", Display_Out, 16'h0006);
        chk("burst.cnt", Char_Count, 16'h0007);

        // Full FIFO, write lands on the cycle the hold expires.
        do_reset();
        for (int i = 1; i <= 5; i++) write1(16'(16'h0010 + i), "fullpop");
        guard = 0;
        while (!(m_vis && m_remain == 1 && mq.size() == DEPTH) && guard < 20) begin
            tick("fullpop_wait");
            guard++;
        end
        chk("fullpop.reached", 16'(guard < 20), 16'h0001);
        chk("fullpop.dsr", 16'(DSR_Ready), 16'h0000);
        write1(16'h0077, "fullpop");
        chk("fullpop.ovf", 16'(Overflow), 16'h0000);
        for (int i = 0; i < 30; i++) tick("fullpop_drain");
        chk("fullpop.last", Display_Out, 16'h0077);
        chk("fullpop.cnt", Char_Count, 16'h0006);

        // Flush while 0x00AA is shown with three entries behind it.
        do_reset();
        write1(16'h00AA, "flush");
        write1(16'h0001, "flush");
        write1(16'h0002, "flush");
        write1(16'h0003, "flush");
        chk("flush.showing", Display_Out, 16'h00AA);
        Flush = 1'b1; DDR_Write = 1'b1; DDR_Data = 16'h00BB;
        tick("flush");
        Flush = 1'b0; DDR_Write = 1'b0;
        chk("flush.still_valid", 16'(Display_Valid), 16'h0001);
        for (int i = 0; i < 10; i++) tick("flush_drain");
        chk("flush.out", Display_Out, 16'h00AA);
        chk("flush.valid", 16'(Display_Valid), 16'h0000);
        chk("flush.cnt", Char_Count, 16'h0001);
        chk("flush.dsr", 16'(DSR_Ready), 16'h0001);
        chk("flush.ovf", 16'(Overflow), 16'h0000);

        // Asynchronous reset in the middle of a hold.
        write1(16'h0055, "areset");
        write1(16'h0056, "areset");
        tick("areset");
        chk("areset.pre", 16'(Display_Valid), 16'h0001);
        Reset_N = 1'b0;
        #1;
        chk("areset.out", Display_Out, 16'h0000);
        chk("areset.valid", 16'(Display_Valid), 16'h0000);
        chk("areset.cnt", Char_Count, 16'h0000);
        chk("areset.dsr", 16'(DSR_Ready), 16'h0000);
        model_reset();
        tick("areset");
        Reset_N = 1'b1;
        #1;
        compare_all("areset_rel");
        for (int i = 0; i < 4; i++) tick("areset_empty");
        chk("areset.empty", 16'(Display_Valid), 16'h0000);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            DDR_Write = ($urandom_range(0, 1) == 1);
            DDR_Data  = 16'($urandom);
            Flush     = ($urandom_range(0, 31) == 0);
            tick("rand");
        end
        DDR_Write = 1'b0; Flush = 1'b0;
        for (int i = 0; i < 30; i++) tick("rand_drain");

        // Char_Count wrap on the one-cycle-hold instance.
        do_reset();
        for (int i = 0; i < 65535; i++) begin
            w_wr = 1'b1; w_data = 16'(i);
            @(posedge Clk); #1;
        end
        w_wr = 1'b0;
        repeat (4) begin @(posedge Clk); #1; end
        chk("wrap.ffff", w_cnt, 16'hFFFF);
        chk("wrap.last", w_out, 16'hFFFE);
        chk("wrap.ovf", 16'(w_ovf), 16'h0000);
        w_wr = 1'b1; w_data = 16'h1234;
        @(posedge Clk); #1;
        w_wr = 1'b0;
        @(posedge Clk); #1;
        chk("wrap.valid", 16'(w_valid), 16'h0001);
        chk("wrap.zero", w_cnt, 16'h0000);
        chk("wrap.out", w_out, 16'h1234);
        @(posedge Clk); #1;
        chk("wrap.valid_fall", 16'(w_valid), 16'h0000);
        chk("wrap.dsr", 16'(w_dsr), 16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
